aib_cfg_bcast_seq: RTL

- Bulk configuration sequencer and bus arbiter for the AIB IO-config register file: 9-bit config word per IO, NumChannels x 96 IOs, reached over the APB-style register bus.
- Takes one broadcast command (channel mask, IO range, 9-bit value) and issues one register write per targeted IO.
- Shares the downstream bus with the UART debug-port master. Sits between dbg_port and the register decode.

---
 rtl/aib_cfg_pkg.sv | 37 +++
 rtl/aib_cfg_bus_arb.sv | 91 +++++++++
 rtl/aib_cfg_bcast_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/aib_cfg_pkg.sv
// Shared constants and types for the AIB IO-config broadcast sequencer.
// Address layout of an IO config register: region [13:12], channel [11:9], io [8:2].
package aib_cfg_pkg;

  localparam int NumIo = 96;
  localparam int CFG_W = 9;

  localparam logic [1:0] REGION_IOB = 2'd2;
  localparam int REGION_LSB = 12;
  localparam int REGION_W   = 2;
  localparam int CH_LSB     = 9;
  localparam int CH_W       = 3;
  localparam int IO_LSB     = 2;
  localparam int IO_W       = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    DBG  = 2'd1,
    SEQ  = 2'd2
  } owner_e;

  function automatic logic [31:0] iob_addr(input logic [CH_W-1:0] ch, input logic [IO_W-1:0] io);
    logic [31:0] a;
    a = 32'd0;
    a[REGION_LSB +: REGION_W] = REGION_IOB;
    a[CH_LSB +: CH_W]         = ch;
    a[IO_LSB +: IO_W]         = io;
    return a;
  endfunction

endpackage

// File: rtl/aib_cfg_bus_arb.sv
// 2:1 arbiter for the register bus: debug master has fixed priority, the
// owner is held from grant until the transaction completes.
module aib_cfg_bus_arb
  import aib_cfg_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_dbg_penable,
  input  logic        i_dbg_pwrite,
  input  logic [31:0] i_dbg_paddr,
  input  logic [31:0] i_dbg_pwdata,
  output logic        o_dbg_pready,
  input  logic        i_seq_penable,
  input  logic        i_seq_pwrite,
  input  logic [31:0] i_seq_paddr,
  input  logic [31:0] i_seq_pwdata,
  output logic        o_seq_gnt,
  output logic        o_penable,
  output logic        o_pwrite,
  output logic [31:0] o_paddr,
  output logic [31:0] o_pwdata,
  input  logic        i_pready
);

  owner_e owner_r;
  owner_e owner_n;
  logic   dbg_gnt_s;
  logic   seq_gnt_s;

  // grant decode and bus mux
  always_comb begin
    dbg_gnt_s = 1'b0;
    seq_gnt_s = 1'b0;
    case (owner_r)
      DBG:  dbg_gnt_s = 1'b1;
      SEQ:  seq_gnt_s = 1'b1;
      NONE: begin
        if (i_dbg_penable) begin
          dbg_gnt_s = 1'b1;
        end else if (i_seq_penable) begin
          seq_gnt_s = 1'b1;
        end else begin
          dbg_gnt_s = 1'b0;
        end
      end
      default: begin
        dbg_gnt_s = 1'b0;
        seq_gnt_s = 1'b0;
      end
    endcase

    o_penable = 1'b0;
    o_pwrite  = 1'b0;
    o_paddr   = 32'd0;
    o_pwdata  = 32'd0;
    if (dbg_gnt_s) begin
      o_penable = i_dbg_penable;
      o_pwrite  = i_dbg_pwrite;
      o_paddr   = i_dbg_paddr;
      o_pwdata  = i_dbg_pwdata;
    end else if (seq_gnt_s) begin
      o_penable = i_seq_penable;
      o_pwrite  = i_seq_pwrite;
      o_paddr   = i_seq_paddr;
      o_pwdata  = i_seq_pwdata;
    end else begin
      o_penable = 1'b0;
    end

    // Owner sticks only across a stalled transfer; a completed one frees the bus.
    owner_n = NONE;
    if (o_penable && !i_pready) begin
      owner_n = dbg_gnt_s ? DBG : SEQ;
    end else begin
      owner_n = NONE;
    end
  end

  assign o_dbg_pready = dbg_gnt_s & i_pready;
  assign o_seq_gnt    = seq_gnt_s;

  // owner register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_r <= NONE;
    end else begin
      owner_r <= owner_n;
    end
  end

endmodule

// File: rtl/aib_cfg_bcast_seq.sv
// Broadcast configuration sequencer: expands one (channel mask, IO range, cfg)
// command into one register write per targeted IO, sharing the bus with dbg_port.
module aib_cfg_bcast_seq
  import aib_cfg_pkg::*;
#(
  parameter int NumChannels = 6,
  parameter int NumIo       = aib_cfg_pkg::NumIo
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [NumChannels-1:0] i_cmd_ch_mask,
  input  logic [6:0]             i_cmd_io_first,
  input  logic [6:0]             i_cmd_io_last,
  input  logic [8:0]             i_cmd_cfg,
  input  logic                   i_abort,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  input  logic                   i_dbg_penable,
  input  logic                   i_dbg_pwrite,
  input  logic [31:0]            i_dbg_paddr,
  input  logic [31:0]            i_dbg_pwdata,
  output logic                   o_dbg_pready,
  output logic [31:0]            o_dbg_prdata,
  output logic                   o_penable,
  output logic                   o_pwrite,
  output logic [31:0]            o_paddr,
  output logic [31:0]            o_pwdata,
  input  logic                   i_pready,
  input  logic [31:0]            i_prdata
);

  localparam logic [6:0] IO_MAX = 7'(NumIo - 1);

  seq_state_e             state_r, state_n;
  logic [2:0]             ch_r, ch_n;
  logic [6:0]             io_r, io_n;
  logic [6:0]             io_first_r, io_last_r;
  logic [NumChannels-1:0] mask_r;
  logic [CFG_W-1:0]       cfg_r;
  logic                   abort_pend_r, abort_pend_n;
  logic                   done_r, err_r, busy_r;

  logic        cmd_fire_s, cmd_bad_s, abort_seen_s, seq_gnt_s, seq_penable_s;
  logic [3:0]  first_ch_s, next_ch_s;
  logic [31:0] seq_paddr_s, seq_pwdata_s;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [3:0] scan_mask(input logic [NumChannels-1:0] mask, input int from);
    logic [3:0] res;
    res = 4'h0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

  assign o_cmd_ready   = (state_r == IDLE);
  assign cmd_fire_s    = i_cmd_valid & o_cmd_ready;
  assign cmd_bad_s     = (i_cmd_ch_mask == '0) || (i_cmd_io_first > i_cmd_io_last) ||
                         (i_cmd_io_last > IO_MAX);
  assign first_ch_s    = scan_mask(i_cmd_ch_mask, 0);
  assign next_ch_s     = scan_mask(mask_r, int'(ch_r) + 1);
  assign abort_seen_s  = i_abort | abort_pend_r;
  assign seq_penable_s = (state_r == RUN);
  assign seq_paddr_s   = iob_addr(ch_r, io_r);
  assign seq_pwdata_s  = {23'd0, cfg_r};

  // next-state, channel/IO walk and abort handling
  always_comb begin
    state_n      = state_r;
    ch_n         = ch_r;
    io_n         = io_r;
    abort_pend_n = abort_pend_r;
    case (state_r)
      IDLE: begin
        abort_pend_n = 1'b0;
        if (cmd_fire_s && !cmd_bad_s) begin
          state_n = RUN;
          ch_n    = first_ch_s[2:0];
          io_n    = i_cmd_io_first;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (seq_gnt_s && i_pready) begin
          if (abort_seen_s) begin
            state_n      = IDLE;
            abort_pend_n = 1'b0;
          end else if (io_r != io_last_r) begin
            io_n = io_r + 7'd1;
          end else if (next_ch_s[3]) begin
            ch_n = next_ch_s[2:0];
            io_n = io_first_r;
          end else begin
            state_n = DONE;
          end
        end else if (seq_gnt_s) begin
          // write in flight: remember the abort, finish the transfer first
          abort_pend_n = abort_seen_s;
        end else if (abort_seen_s) begin
          state_n      = IDLE;
          abort_pend_n = 1'b0;
        end else begin
          state_n = RUN;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM, walk counters and status pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      ch_r         <= 3'd0;
      io_r         <= 7'd0;
      abort_pend_r <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_n;
      ch_r         <= ch_n;
      io_r         <= io_n;
      abort_pend_r <= abort_pend_n;
      done_r       <= (state_n == DONE);
      err_r        <= cmd_fire_s & cmd_bad_s;
      busy_r       <= (state_n != IDLE);
    end
  end

  // command capture at accept
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask_r     <= '0;
      io_first_r <= 7'd0;
      io_last_r  <= 7'd0;
      cfg_r      <= 9'd0;
    end else if (cmd_fire_s && !cmd_bad_s) begin
      mask_r     <= i_cmd_ch_mask;
      io_first_r <= i_cmd_io_first;
      io_last_r  <= i_cmd_io_last;
      cfg_r      <= i_cmd_cfg;
    end else begin
      mask_r     <= mask_r;
    end
  end

  assign o_done       = done_r;
  assign o_err        = err_r;
  assign o_busy       = busy_r;
  assign o_dbg_prdata = i_prdata;

  aib_cfg_bus_arb u_arb (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_dbg_penable (i_dbg_penable),
    .i_dbg_pwrite  (i_dbg_pwrite),
    .i_dbg_paddr   (i_dbg_paddr),
    .i_dbg_pwdata  (i_dbg_pwdata),
    .o_dbg_pready  (o_dbg_pready),
    .i_seq_penable (seq_penable_s),
    .i_seq_pwrite  (1'b1),
    .i_seq_paddr   (seq_paddr_s),
    .i_seq_pwdata  (seq_pwdata_s),
    .o_seq_gnt     (seq_gnt_s),
    .o_penable     (o_penable),
    .o_pwrite      (o_pwrite),
    .o_paddr       (o_paddr),
    .o_pwdata      (o_pwdata),
    .i_pready      (i_pready)
  );

endmodule
